alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID->EX pipeline register that directly feeds the ALU.
//  - Latches decoded operands, immediate, PC and the 4-bit ALU select.
//  - Selects the ALU a/b sources: rs1 or PC for a, rs2 or immediate for b.
//  - Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
//  - Applies valid/ready backpressure toward decode; accepts a flush from branch resolution.
// PARAMETERS
//  XLEN        32  datapath width
//  RA_W        5   register-address width
//  SEL_W       4   ALU select width (ALU opcode encoding passed through unchanged)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      synchronous squash of held/incoming instruction
//  dec_valid    in   1      decode presents an instruction
//  dec_ready    out  1      stage can accept this cycle
//  dec_rs1/rs2  in   RA_W   source register addresses
//  dec_rs1_d/rs2_d in XLEN  register-file read data
//  dec_imm      in   XLEN   sign-extended immediate
//  dec_pc       in   XLEN   instruction PC
//  dec_use_pc   in   1      a = PC instead of rs1
//  dec_use_imm  in   1      b = imm instead of rs2
//  dec_sel      in   SEL_W  ALU select
//  dec_rd       in   RA_W   destination register
//  dec_we       in   1      writes rd
//  exm_we/exm_rd/exm_d in 1/RA_W/XLEN  EX/MEM result for forwarding
//  wb_we/wb_rd/wb_d    in 1/RA_W/XLEN  MEM/WB result for forwarding
//  ex_valid     out  1      ALU operands valid
//  ex_ready     in   1      EX consumes this cycle
//  alu_a/alu_b  out  XLEN   ALU operands (combinational from held state + forwarding)
//  alu_sel      out  SEL_W  registered select
//  ex_rd/ex_we/ex_pc out RA_W/1/XLEN  registered passthrough
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - ex_valid=0; all held registers=0.
//  - alu_a=alu_b=0; alu_sel=0 (add); ex_we=0.
//  Handshake:
//  - dec_ready = !ex_valid | ex_ready (single register, no skid buffer).
//  - Accept when dec_valid & dec_ready. Latency 1 cycle: accept at edge N, ex_valid=1 after N.
//  - Held contents are stable while ex_valid & !ex_ready.
//  - ex_valid & ex_ready & !accept -> ex_valid=0 next cycle.
//  - Simultaneous consume+accept -> back-to-back, no bubble.
//  Flush:
//  - flush=1 -> ex_valid=0 next edge; same-cycle dec input is discarded.
//  - Flush overrides accept and hold.
//  - dec_ready is unaffected by flush.
//  Forwarding (rs operands only, never when use_pc/use_imm):
//  - Match = src_we & src_rd==held_rs & held_rs!=0.
//  - EX/MEM wins over MEM/WB; no match -> held register data.
//  - Applied combinationally to alu_a/alu_b only while ex_valid=1.
//  Refresh during stall:
//  - Each cycle ex_valid & !ex_ready, a MEM/WB match overwrites the held rs data.
//  - Prevents loss of a value that retires while stalled.
//  - EX/MEM is not written into the held registers.
//  x0 is never forwarded or refreshed.
//  Operand width: plain XLEN copies; no arithmetic in this stage.
//  Reset mid-stall: drops the instruction; no output glitch other than to 0.
// CONFIGURATION
//  OPERAND_FWD_EN defined:
//  - Forwarding and stall refresh as above.
//  OPERAND_FWD_EN undefined:
//  - exm_*/wb_* ports present but ignored.
//  - alu_a/alu_b come straight from the held registers (a valid-gated 0 when !ex_valid).
//  - Hazards are the hazard unit's job (it must stall decode).
// TESTING
//  1 Reset:
//    - rst_n=0 mid-operation -> ex_valid=0, alu_a=alu_b=0 immediately (async).
//  2 Accept/pass:
//    - rs1_d=5, rs2_d=7, sel=0000, ex_ready=1 -> next cycle ex_valid=1, a=5, b=7, sel=0000.
//  3 Imm/PC select:
//    - use_pc=1, pc=0x100, use_imm=1, imm=0xFFFFFFFC -> a=0x100, b=0xFFFFFFFC.
//    - Same with exm_rd==rs1 -> no forward.
//  4 Forward priority:
//    - rs1=3, exm_rd=3 exm_d=0xAA, wb_rd=3 wb_d=0xBB -> a=0xAA.
//    - exm_we=0 -> a=0xBB.
//    - rs1=0 -> a=held data.
//  5 Stall refresh:
//    - ex_ready=0 3 cycles; wb_rd=rs2 wb_d=0x55 in cycle 1 then gone.
//    - -> b=0x55 when ex_ready=1; dec_ready=0 throughout.
//  6 Flush vs accept:
//    - flush=1 with dec_valid=1, dec_ready=1 -> ex_valid=0 next cycle.
//    - Back-to-back accepts with ex_ready=1 -> no bubble.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Bundle of decode, EX handshake and forwarding-source signals
//               for the ID->EX operand stage. The master side is
//               decode/EX/forwarding. The slave side is the operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int SEL_W = 4
);
    // Decode side
    logic             flush;
    logic             dec_valid;
    logic             dec_ready;
    logic [RA_W-1:0]  dec_rs1;
    logic [RA_W-1:0]  dec_rs2;
    logic [XLEN-1:0]  dec_rs1_d;
    logic [XLEN-1:0]  dec_rs2_d;
    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  dec_pc;
    logic             dec_use_pc;
    logic             dec_use_imm;
    logic [SEL_W-1:0] dec_sel;
    logic [RA_W-1:0]  dec_rd;
    logic             dec_we;
    // Forwarding sources
    logic             exm_we;
    logic [RA_W-1:0]  exm_rd;
    logic [XLEN-1:0]  exm_d;
    logic             wb_we;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_d;
    // EX side
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_we;
    logic [XLEN-1:0]  ex_pc;

    modport master (
        output flush, dec_valid, dec_rs1, dec_rs2, dec_rs1_d, dec_rs2_d,
               dec_imm, dec_pc, dec_use_pc, dec_use_imm, dec_sel, dec_rd,
               dec_we, exm_we, exm_rd, exm_d, wb_we, wb_rd, wb_d, ex_ready,
        input  dec_ready, ex_valid, alu_a, alu_b, alu_sel, ex_rd, ex_we, ex_pc
    );

    modport slave (
        input  flush, dec_valid, dec_rs1, dec_rs2, dec_rs1_d, dec_rs2_d,
               dec_imm, dec_pc, dec_use_pc, dec_use_imm, dec_sel, dec_rd,
               dec_we, exm_we, exm_rd, exm_d, wb_we, wb_rd, wb_d, ex_ready,
        output dec_ready, ex_valid, alu_a, alu_b, alu_sel, ex_rd, ex_we, ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : ID->EX pipeline register feeding the ALU. It holds the
//               operands, immediate, PC and ALU select. It picks rs1/PC for a
//               and rs2/imm for b. It uses a valid/ready handshake and can be
//               flushed. Define OPERAND_FWD_EN to add EX/MEM and MEM/WB
//               forwarding, and to refresh held operands while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int SEL_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_operand_stage_if.slave  bus
);

    logic             valid_q,      valid_d;
    logic [RA_W-1:0]  rs1_q,        rs1_d;
    logic [RA_W-1:0]  rs2_q,        rs2_d;
    logic [XLEN-1:0]  rs1_data_q,   rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,   rs2_data_d;
    logic [XLEN-1:0]  imm_q,        imm_d;
    logic [XLEN-1:0]  pc_q,         pc_d;
    logic             use_pc_q,     use_pc_d;
    logic             use_imm_q,    use_imm_d;
    logic [SEL_W-1:0] sel_q,        sel_d;
    logic [RA_W-1:0]  rd_q,         rd_d;
    logic             we_q,         we_d;

    logic             w_dec_ready;
    logic             w_accept;
    logic             w_stall;
    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;

    // Single-entry register: a slot is free when empty or being drained.
    assign w_dec_ready = !valid_q || bus.ex_ready;
    assign w_accept    = bus.dec_valid && w_dec_ready;
    assign w_stall     = valid_q && !bus.ex_ready;

`ifdef OPERAND_FWD_EN
    // Forwarding: EX/MEM has priority over MEM/WB, and x0 is never matched.
    always_comb begin
        w_rs1_val = rs1_data_q;
        w_rs2_val = rs2_data_q;
        if (bus.exm_we && (bus.exm_rd == rs1_q) && (rs1_q != '0))
            w_rs1_val = bus.exm_d;
        else if (bus.wb_we && (bus.wb_rd == rs1_q) && (rs1_q != '0))
            w_rs1_val = bus.wb_d;
        if (bus.exm_we && (bus.exm_rd == rs2_q) && (rs2_q != '0))
            w_rs2_val = bus.exm_d;
        else if (bus.wb_we && (bus.wb_rd == rs2_q) && (rs2_q != '0))
            w_rs2_val = bus.wb_d;
    end
`else
    // Hazards are resolved upstream, so the held data goes out unchanged.
    logic w_unused_fwd;
    assign w_rs1_val    = rs1_data_q;
    assign w_rs2_val    = rs2_data_q;
    assign w_unused_fwd = ^{bus.exm_we, bus.exm_rd, bus.exm_d,
                            bus.wb_we, bus.wb_rd, bus.wb_d};
`endif

    // Next state: flush beats accept, accept beats hold/drain.
    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        use_pc_d   = use_pc_q;
        use_imm_d  = use_imm_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        we_d       = we_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d    = 1'b1;
            rs1_d      = bus.dec_rs1;
            rs2_d      = bus.dec_rs2;
            rs1_data_d = bus.dec_rs1_d;
            rs2_data_d = bus.dec_rs2_d;
            imm_d      = bus.dec_imm;
            pc_d       = bus.dec_pc;
            use_pc_d   = bus.dec_use_pc;
            use_imm_d  = bus.dec_use_imm;
            sel_d      = bus.dec_sel;
            rd_d       = bus.dec_rd;
            we_d       = bus.dec_we;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end else if (w_stall) begin
`ifdef OPERAND_FWD_EN
            // A value retiring from WB while stalled would otherwise be lost.
            if (bus.wb_we && (bus.wb_rd == rs1_q) && (rs1_q != '0))
                rs1_data_d = bus.wb_d;
            if (bus.wb_we && (bus.wb_rd == rs2_q) && (rs2_q != '0))
                rs2_data_d = bus.wb_d;
`endif
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            use_pc_q   <= 1'b0;
            use_imm_q  <= 1'b0;
            sel_q      <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            use_pc_q   <= use_pc_d;
            use_imm_q  <= use_imm_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
        end
    end

    assign bus.dec_ready = w_dec_ready;
    assign bus.ex_valid  = valid_q;
    assign bus.alu_a     = valid_q ? (use_pc_q  ? pc_q  : w_rs1_val) : '0;
    assign bus.alu_b     = valid_q ? (use_imm_q ? imm_q : w_rs2_val) : '0;
    assign bus.alu_sel   = sel_q;
    assign bus.ex_rd     = rd_q;
    assign bus.ex_we     = we_q;
    assign bus.ex_pc     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench for alu_operand_stage. It
//               covers reset, the handshake, source selection, forwarding,
//               stall refresh and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   n_fail;

    alu_operand_stage_if #(.XLEN(32), .RA_W(5), .SEL_W(4)) bus ();

    alu_operand_stage #(.XLEN(32), .RA_W(5), .SEL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2);
        bus.dec_rs1   = rs1;
        bus.dec_rs1_d = d1;
        bus.dec_rs2   = rs2;
        bus.dec_rs2_d = d2;
    endtask

    initial begin
        logic [31:0] exp_b;
        n_total = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.flush = 0; bus.dec_valid = 0; bus.dec_imm = 0; bus.dec_pc = 0;
        bus.dec_use_pc = 0; bus.dec_use_imm = 0; bus.dec_sel = 0;
        bus.dec_rd = 0; bus.dec_we = 0; bus.exm_we = 0; bus.exm_rd = 0;
        bus.exm_d = 0; bus.wb_we = 0; bus.wb_rd = 0; bus.wb_d = 0;
        bus.ex_ready = 1;
        drive(5'd0, 32'h0, 5'd0, 32'h0);
        #3;
        chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("rst_alu_a",    bus.alu_a,             32'h0);
        chk("rst_alu_b",    bus.alu_b,             32'h0);
        chk("rst_alu_sel",  {28'b0, bus.alu_sel},  32'h0);
        chk("rst_ex_we",    {31'b0, bus.ex_we},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic accept and pass-through
        drive(5'd1, 32'd5, 5'd2, 32'd7);
        bus.dec_sel = 4'b0000; bus.dec_rd = 5'd4; bus.dec_we = 1; bus.dec_valid = 1;
        chk("pre_dec_ready", {31'b0, bus.dec_ready}, 32'h1);
        tick();
        bus.dec_valid = 0;
        chk("acc_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        chk("acc_alu_a",    bus.alu_a,             32'd5);
        chk("acc_alu_b",    bus.alu_b,             32'd7);
        chk("acc_alu_sel",  {28'b0, bus.alu_sel},  32'h0);
        chk("acc_ex_rd",    {27'b0, bus.ex_rd},    32'd4);
        chk("acc_ex_we",    {31'b0, bus.ex_we},    32'h1);
        tick();
        chk("drain_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("drain_alu_a",    bus.alu_a,             32'h0);

        // PC/immediate select, forwarding must not apply
        drive(5'd3, 32'd9, 5'd3, 32'd9);
        bus.dec_use_pc = 1; bus.dec_pc = 32'h100; bus.dec_use_imm = 1;
        bus.dec_imm = 32'hFFFF_FFFC; bus.dec_sel = 4'b1010; bus.dec_valid = 1;
        bus.exm_we = 1; bus.exm_rd = 5'd3; bus.exm_d = 32'hAA;
        tick();
        bus.dec_valid = 0; bus.ex_ready = 0;
        chk("pc_alu_a",    bus.alu_a,            32'h100);
        chk("imm_alu_b",   bus.alu_b,            32'hFFFF_FFFC);
        chk("pc_alu_sel",  {28'b0, bus.alu_sel}, 32'hA);
        chk("pc_ex_pc",    bus.ex_pc,            32'h100);
        tick();
        chk("hold_alu_a",    bus.alu_a,             32'h100);
        chk("hold_dec_ready",{31'b0, bus.dec_ready}, 32'h0);
        bus.ex_ready = 1; bus.exm_we = 0;
        tick();
        bus.dec_use_pc = 0; bus.dec_use_imm = 0;

        // Forward priority (combinational, checked within one held cycle)
        drive(5'd3, 32'h11, 5'd0, 32'h22);
        bus.dec_valid = 1;
        tick();
        bus.dec_valid = 0; bus.ex_ready = 0;
        bus.exm_we = 1; bus.exm_rd = 5'd3; bus.exm_d = 32'hAA;
        bus.wb_we = 1;  bus.wb_rd = 5'd3;  bus.wb_d = 32'hBB;
        #1;
`ifdef OPERAND_FWD_EN
        chk("fwd_exm_wins", bus.alu_a, 32'hAA);
`else
        chk("nofwd_exm", bus.alu_a, 32'h11);
`endif
        bus.exm_we = 0;
        #1;
`ifdef OPERAND_FWD_EN
        chk("fwd_wb", bus.alu_a, 32'hBB);
`else
        chk("nofwd_wb", bus.alu_a, 32'h11);
`endif
        bus.wb_we = 0;
        #1;
        chk("fwd_none", bus.alu_a, 32'h11);
        bus.exm_we = 1; bus.exm_rd = 5'd0; bus.exm_d = 32'hCC;
        bus.wb_we = 1;  bus.wb_rd = 5'd0;  bus.wb_d = 32'hDD;
        #1;
        chk("fwd_x0", bus.alu_b, 32'h22);
        bus.exm_we = 0; bus.wb_we = 0; bus.ex_ready = 1;
        tick();

        // Stall refresh from MEM/WB
        drive(5'd0, 32'h1, 5'd6, 32'h33);
        bus.dec_valid = 1;
        tick();
        bus.ex_ready = 0;
        drive(5'd1, 32'h77, 5'd2, 32'h88);
        bus.wb_we = 1; bus.wb_rd = 5'd6; bus.wb_d = 32'h55;
`ifdef OPERAND_FWD_EN
        exp_b = 32'h55;
`else
        exp_b = 32'h33;
`endif
        #1;
        chk("stall1_dec_ready", {31'b0, bus.dec_ready}, 32'h0);
        tick();
        bus.wb_we = 0;
        #1;
        chk("stall2_alu_b",     bus.alu_b,              exp_b);
        chk("stall2_dec_ready", {31'b0, bus.dec_ready}, 32'h0);
        tick();
        chk("stall3_alu_b",     bus.alu_b,              exp_b);
        chk("stall3_dec_ready", {31'b0, bus.dec_ready}, 32'h0);
        bus.ex_ready = 1;
        #1;
        chk("release_alu_b",    bus.alu_b,              exp_b);

        // Back-to-back accepts, no bubble
        tick();
        chk("b2b1_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        chk("b2b1_alu_a",    bus.alu_a,             32'h77);
        drive(5'd1, 32'h99, 5'd2, 32'h9A);
        tick();
        chk("b2b2_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        chk("b2b2_alu_a",    bus.alu_a,             32'h99);

        // Flush beats accept; dec_ready unaffected
        drive(5'd1, 32'h44, 5'd2, 32'h45);
        bus.flush = 1;
        #1;
        chk("flush_dec_ready", {31'b0, bus.dec_ready}, 32'h1);
        tick();
        bus.flush = 0;
        chk("flush_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("flush_alu_a",    bus.alu_a,             32'h0);

        // Flush beats hold
        tick();
        bus.dec_valid = 0; bus.ex_ready = 0;
        chk("fh_pre_valid", {31'b0, bus.ex_valid}, 32'h1);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("fh_ex_valid", {31'b0, bus.ex_valid}, 32'h0);

        // Asynchronous reset in the middle of a stall
        drive(5'd1, 32'h12, 5'd2, 32'h34);
        bus.dec_sel = 4'b0110; bus.dec_valid = 1;
        tick();
        bus.dec_valid = 0;
        chk("ms_pre_alu_a", bus.alu_a, 32'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ms_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("ms_alu_a",    bus.alu_a,             32'h0);
        chk("ms_alu_b",    bus.alu_b,             32'h0);
        chk("ms_alu_sel",  {28'b0, bus.alu_sel},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
